// File: rtl/alu_dispatch_if.sv
// Request/result handshake bundle between an issuing master and the alu_dispatch stage.
interface alu_dispatch_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_flags;

    modport master (
        output req_valid, req_op, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_flags
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_flags
    );
endinterface

// File: rtl/alu_dispatch.sv
// Issue stage for the arithmetic cells: latches one request, waits the per-op settle
// latency, captures a 16-bit result with Z/C/DZ flags and hands it downstream.
module alu_dispatch #(
    parameter int unsigned MUL_CYCLES = 2,  // legal range 1..15
    parameter int unsigned DIV_CYCLES = 4   // legal range 1..15
) (
    input  logic         clk,
    input  logic         rst,
    alu_dispatch_if.slave bus,
    output logic [15:0]  op_count
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpDiv = 2'b11;

    localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DivLoad = 4'(DIV_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        res_valid_q, res_valid_d;
    logic [15:0] res_data_q, res_data_d;
    logic [2:0]  res_flags_q, res_flags_d;
    logic [15:0] op_count_q, op_count_d;

    logic        req_ready;
    logic        accept;

    // Arithmetic cells, fed only from the latched operand registers.
    logic [8:0]  sum9;
    logic [7:0]  minus;
    logic [15:0] product;
    logic [7:0]  b_safe;
    logic [7:0]  quotient;

    assign sum9     = {1'b0, a_q} + {1'b0, b_q};
    assign minus    = a_q - b_q;
    assign product  = {8'h00, a_q} * {8'h00, b_q};
    // Divisor forced non-zero so the divider never yields X; the DZ path overrides it.
    assign b_safe   = (b_q == 8'h00) ? 8'h01 : b_q;
    assign quotient = a_q / b_safe;

    logic [15:0] cap_data;
    logic        cap_c;
    logic        cap_dz;

    always_comb begin
        cap_data = 16'h0000;
        cap_c    = 1'b0;
        cap_dz   = 1'b0;
        case (op_q)
            OpAdd: begin
                cap_data = {8'h00, sum9[7:0]};
                cap_c    = sum9[8];
            end
            OpSub: begin
                cap_data = {8'h00, minus};
                cap_c    = (a_q < b_q);
            end
            OpMul: cap_data = product;
            OpDiv: begin
                if (b_q == 8'h00) begin
                    cap_data = 16'h00FF;
                    cap_dz   = 1'b1;
                end else begin
                    cap_data = {8'h00, quotient};
                end
            end
            default: cap_data = 16'h0000;
        endcase
    end

    function automatic logic [3:0] load_of(input logic [1:0] op);
        case (op)
            OpMul:   return MulLoad;
            OpDiv:   return DivLoad;
            default: return 4'd0;
        endcase
    endfunction

    assign req_ready = (state_q == StIdle) || ((state_q == StDone) && bus.res_ready);
    assign accept    = bus.req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        op_count_d  = op_count_q;

        case (state_q)
            StIdle: ;
            StExec: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_data_d  = cap_data;
                    res_flags_d = {cap_dz, cap_c, (cap_data == 16'h0000)};
                    res_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.res_ready) begin
                    op_count_d  = op_count_q + 16'd1;
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Accept only happens in IDLE or in DONE alongside the result handshake.
        if (accept) begin
            a_d     = bus.req_a;
            b_d     = bus.req_b;
            op_d    = bus.req_op;
            cnt_d   = load_of(bus.req_op);
            state_d = StExec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            op_q        <= 2'b00;
            cnt_q       <= 4'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 16'h0000;
            res_flags_q <= 3'b000;
            op_count_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_flags = res_flags_q;
    assign op_count      = op_count_q;

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- Issue/sequencing stage directly upstream of the arithmetic cells. Accepts one operation request at a time over a valid/ready handshake and latches the operands. Drives Sum_cell, Minus_cell, Multiply_cell and Division_cell from stable registers, waits a per-operation settle latency, then captures a 16-bit result and flags. Presents the result downstream over a second valid/ready handshake.
- Division and multiplication paths are treated as multi-cycle; this block owns that timing.

Parameters:
- MUL_CYCLES, 2, cycles from accept to result capture for MUL; legal range 1..15.
- DIV_CYCLES, 4, cycles from accept to result capture for DIV; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- req_a  input  8  operand A.
- req_b  input  8  operand B.
- res_valid  output  1  result present.
- res_ready  input  1  consumer accepts result.
- res_data  output  16  result.
- res_flags  output  3  [0] Z, [1] C (carry/borrow), [2] DZ (divide by zero).
- op_count  output  16  completed-operation counter.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (asserts immediately, independent of clk):
  - state = IDLE.
  - res_valid = 0, res_data = 16'h0000, res_flags = 3'b000, op_count = 16'h0000.
  - Operand/op registers = 0, latency counter = 0.
  - req_ready = 1 (combinational from IDLE).
- FSM states: IDLE, EXEC, DONE.
- req_ready = (state==IDLE) || (state==DONE && res_ready). Purely combinational; no other path.
- Accept occurs on a rising edge with req_valid && req_ready:
  - Latch req_a, req_b, req_op.
  - Load the counter with L-1, where L = 1 for ADD/SUB, MUL_CYCLES for MUL, DIV_CYCLES for DIV.
  - Go to EXEC.
  - req_* are ignored on all other cycles.
- EXEC:
  - If counter != 0, decrement.
  - If counter == 0, capture the result, set res_valid = 1, go to DONE.
  - Net effect: res_valid rises exactly L edges after the accept edge.
- Result capture rules:
  - ADD: res_data = {8'h00, sum}; C = 9-bit carry-out of a+b.
  - SUB: res_data = {8'h00, minus}; C = (a < b), i.e. borrow.
  - MUL: res_data = 16-bit product; C = 0.
  - DIV, b != 0: res_data = {8'h00, quotient}; C = 0; DZ = 0.
  - DIV, b == 0: res_data = 16'h00FF; DZ = 1. The Division_cell output is ignored (the capture mux must not propagate X).
  - All ops: Z = (res_data == 0). DZ = 0 for all non-DIV ops.
- DONE:
  - res_valid, res_data and res_flags are held stable until res_ready.
  - On res_valid && res_ready: op_count increments, wrapping 16'hFFFF -> 16'h0000.
  - Without a simultaneous accept: go to IDLE, res_valid = 0.
  - With a simultaneous accept (req_valid high on the same edge): the new request is latched and the FSM goes straight to EXEC; res_valid drops to 0.
- res_data and res_flags keep their last captured value after the handshake until the next capture.
- Reset mid-operation (EXEC or DONE): the in-flight op is discarded, is not counted, and all outputs return to reset values.
- Throughput:
  - L+1 cycles per op with back-to-back handshakes.
  - L+2 cycles per op when passing through IDLE.

Test Plan:
1. Reset, then ADD a=200 b=100 -> res_valid one edge after accept, res_data=16'h002C, flags=3'b010, op_count=1 after the handshake.
2. SUB 5-7 -> res_data=16'h00FE, flags=3'b010. Then SUB 9-9 -> res_data=16'h0000, flags=3'b001.
3. MUL 255*255 with MUL_CYCLES=2 -> res_valid exactly 2 edges after accept, res_data=16'hFE01, flags=3'b000. Repeat with DIV_CYCLES=4 for DIV 200/7 -> 4 edges, res_data=16'h001C.
4. DIV 13/0 -> res_data=16'h00FF, flags=3'b100, no X on any output.
5. Hold res_ready=0 for 5 cycles in DONE -> res_* stable and req_ready=0. Then res_ready=1 with req_valid=1 (ADD 1+1) on the same edge -> new op accepted, op_count +1, next result 16'h0002 one edge later.
6. Assert rst two cycles into a DIV (DIV_CYCLES=4) -> outputs immediately at reset values, op_count=0, no res_valid pulse after release. Also preload op_count=16'hFFFF by force and complete an op -> op_count wraps to 16'h0000.
